// File: rtl/spi_link_pkg.sv
// Shared definitions for the master->slave SPI counter link.
package spi_link_pkg;

  localparam int unsigned COUNT_W    = 14;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned PAD_BITS   = 2;
  localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } spi_rx_state_t;

  typedef logic [COUNT_W-1:0] count_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall detect
// taken from one extra register after the synchronized output.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_VAL    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  generate
    if (SYNC_STAGES < 2) begin : g_stage_chk
      $error("spi_sync_edge: SYNC_STAGES must be at least 2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] chain;
  logic                   q_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {SYNC_STAGES{IDLE_VAL}};
      q_d   <= IDLE_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      q_d   <= chain[SYNC_STAGES-1];
    end
  end

  assign q      = chain[SYNC_STAGES-1];
  assign rise_c = q & ~q_d;
  assign fall_c = ~q & q_d;

endmodule

// File: rtl/spi_counter_slave_rx.sv
// SPI mode-0 responder: rebuilds the counter from 2-byte MSB-first frames
// and presents the last good value to the display path.
module spi_counter_slave_rx
  import spi_link_pkg::*;
#(
  parameter int unsigned COUNT_W     = spi_link_pkg::COUNT_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_sclk,
  input  logic               i_mosi,
  input  logic               i_ss_n,
  input  logic               i_clear,
  output logic [COUNT_W-1:0] o_counter,
  output logic               o_valid,
  output logic               o_frame_err,
  output logic               o_busy
);

  generate
    if (COUNT_W > FRAME_BITS || COUNT_W < 2) begin : g_width_chk
      $error("spi_counter_slave_rx: COUNT_W must be in 2..FRAME_BITS");
    end
  endgenerate

  logic s_sclk_unused, sclk_rise, sclk_fall_unused;
  logic s_mosi, mosi_rise_unused, mosi_fall_unused;
  logic s_ss_n_unused, ss_rise, ss_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (i_sclk),
    .q      (s_sclk_unused),
    .rise_c (sclk_rise),
    .fall_c (sclk_fall_unused)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_mosi_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (i_mosi),
    .q      (s_mosi),
    .rise_c (mosi_rise_unused),
    .fall_c (mosi_fall_unused)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (i_ss_n),
    .q      (s_ss_n_unused),
    .rise_c (ss_rise),
    .fall_c (ss_fall)
  );

  spi_rx_state_t          state, state_nx;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_nx;
  // Only the low COUNT_W bits are kept; pad bits shift out of the top.
  logic [COUNT_W-1:0]     shift, shift_nx;
  logic                   load, load_nx;
  logic                   err_nx, busy_nx;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    load_nx    = 1'b0;
    err_nx     = 1'b0;
    busy_nx    = o_busy;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          bit_cnt_nx = '0;
          shift_nx   = '0;
          busy_nx    = 1'b1;
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          err_nx   = (bit_cnt != BIT_CNT_W'(FRAME_BITS));
        end else if (sclk_rise) begin
          shift_nx   = {shift[COUNT_W-2:0], s_mosi};
          bit_cnt_nx = bit_cnt + BIT_CNT_W'(1);
          if (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) begin
            state_nx = DONE;
            load_nx  = 1'b1;
          end
        end
      end
      DONE: begin
        // Extra SCLK edges are ignored; bit_cnt stays saturated.
        if (ss_rise) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          err_nx   = (bit_cnt != BIT_CNT_W'(FRAME_BITS));
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= '0;
      shift       <= '0;
      load        <= 1'b0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
      o_counter   <= '0;
    end else begin
      bit_cnt     <= bit_cnt_nx;
      shift       <= shift_nx;
      load        <= load_nx;
      o_valid     <= load;
      o_frame_err <= err_nx;
      o_busy      <= busy_nx;
      // Clear wins over a same-cycle frame load; o_valid still pulses.
      if (i_clear)   o_counter <= '0;
      else if (load) o_counter <= shift;
    end
  end

endmodule

// File: tb/tb_spi_counter_slave_rx.sv
// Directed bench for spi_counter_slave_rx: whole, short, long, cleared and
// reset-interrupted frames with hand-computed expectations.
module tb_spi_counter_slave_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_sclk = 1'b0;
  logic        i_mosi = 1'b0;
  logic        i_ss_n = 1'b1;
  logic        i_clear = 1'b0;
  logic [13:0] o_counter;
  logic        o_valid, o_frame_err, o_busy;

  int          checks = 0;
  int          errors = 0;
  int          valid_cnt = 0;
  int          err_cnt = 0;
  logic [13:0] cnt_at_valid = '0;
  int          busy_lat = 0;
  logic        busy_seen = 1'b0;

  spi_counter_slave_rx #(.COUNT_W(14), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_sclk      (i_sclk),
    .i_mosi      (i_mosi),
    .i_ss_n      (i_ss_n),
    .i_clear     (i_clear),
    .o_counter   (o_counter),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_valid) begin
      valid_cnt++;
      cnt_at_valid = o_counter;
    end
    if (o_frame_err) err_cnt++;
  end

  // SCLK at 1/10 clk; bits beyond 16 are sent as ones. reset_after < 0 disables the mid-frame reset.
  task automatic send_frame(input logic [15:0] w, input int nbits, input int reset_after);
    busy_seen = 1'b0;
    @(negedge clk) i_ss_n = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      i_mosi = (i < 16) ? w[15-i] : 1'b1;
      repeat (5) @(negedge clk);
      i_sclk = 1'b1;
      repeat (5) @(negedge clk);
      if (o_busy) busy_seen = 1'b1;
      i_sclk = 1'b0;
      if (i == reset_after) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    repeat (5) @(negedge clk);
    i_ss_n = 1'b1;
    busy_lat = 0;
    while (o_busy && busy_lat < 20) begin
      @(negedge clk);
      busy_lat++;
    end
    repeat (10) @(negedge clk);
    i_mosi = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (o_counter !== 14'd0) begin errors++; $display("FAIL reset_counter got %h want 0", o_counter); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", o_frame_err); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
  endtask

  task automatic test_single();
    valid_cnt = 0; err_cnt = 0;
    send_frame(16'h0005, 16, -1);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL single_valid_cnt got %0d want 1", valid_cnt); end
    checks++; if (o_counter !== 14'd5) begin errors++; $display("FAIL single_counter got %0d want 5", o_counter); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL single_err_cnt got %0d want 0", err_cnt); end
    checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL single_busy_high got %b want 1", busy_seen); end
    checks++; if (busy_lat < 2 || busy_lat > 3) begin errors++; $display("FAIL single_busy_fall got %0d want 2..3", busy_lat); end
  endtask

  task automatic test_values();
    logic [15:0] words [4];
    logic [13:0] exp   [4];
    words = '{16'h0001, 16'h2710, 16'h3FFF, 16'hC123};
    exp   = '{14'd1, 14'd10000, 14'd16383, 14'h0123};
    valid_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      send_frame(words[k], 16, -1);
      checks++;
      if (o_counter !== exp[k]) begin
        errors++; $display("FAIL values_%0d got %h want %h", k, o_counter, exp[k]);
      end
    end
    checks++; if (valid_cnt !== 4) begin errors++; $display("FAIL values_valid_cnt got %0d want 4", valid_cnt); end
  endtask

  task automatic test_short_frame();
    send_frame(16'h0005, 16, -1);
    valid_cnt = 0; err_cnt = 0;
    send_frame(16'h0042, 11, -1);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL short_err_cnt got %0d want 1", err_cnt); end
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL short_valid_cnt got %0d want 0", valid_cnt); end
    checks++; if (o_counter !== 14'd5) begin errors++; $display("FAIL short_counter got %0d want 5", o_counter); end
  endtask

  task automatic test_long_frame();
    valid_cnt = 0; err_cnt = 0;
    send_frame(16'h00A5, 20, -1);
    checks++; if (o_counter !== 14'h00A5) begin errors++; $display("FAIL long_counter got %h want 00a5", o_counter); end
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL long_valid_cnt got %0d want 1", valid_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL long_err_cnt got %0d want 0", err_cnt); end
  endtask

  task automatic test_clear();
    valid_cnt = 0;
    cnt_at_valid = 14'h3FFF;
    i_clear = 1'b1;
    send_frame(16'h0007, 16, -1);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL clear_valid_cnt got %0d want 1", valid_cnt); end
    checks++; if (cnt_at_valid !== 14'd0) begin errors++; $display("FAIL clear_counter_at_valid got %0d want 0", cnt_at_valid); end
    i_clear = 1'b0;
    send_frame(16'h0008, 16, -1);
    checks++; if (o_counter !== 14'd8) begin errors++; $display("FAIL clear_release got %0d want 8", o_counter); end
  endtask

  task automatic test_reset_mid_frame();
    valid_cnt = 0;
    send_frame(16'h0009, 16, 8);
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL midreset_valid_cnt got %0d want 0", valid_cnt); end
    checks++; if (o_counter !== 14'd0) begin errors++; $display("FAIL midreset_counter got %0d want 0", o_counter); end
    send_frame(16'h0003, 16, -1);
    checks++; if (o_counter !== 14'd3) begin errors++; $display("FAIL midreset_next got %0d want 3", o_counter); end
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL midreset_next_valid got %0d want 1", valid_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_values();
    test_short_frame();
    test_long_frame();
    test_clear();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
